// File: rtl/imem_cache_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
// Every width derives from the three cache parameters.
package imem_cache_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_REQ,
    ST_FILL,
    ST_RESP
  } state_t;

  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_LINES      = 64;
  localparam int DEF_LINE_WORDS = 4;

  localparam int DEF_WOFS_W = $clog2(DEF_LINE_WORDS);
  localparam int DEF_OFS_W  = DEF_WOFS_W + 2;
  localparam int DEF_IDX_W  = $clog2(DEF_LINES);
  localparam int DEF_TAG_W  = DEF_ADDR_W - DEF_OFS_W - DEF_IDX_W;

  // RISC-V "addi x0, x0, 0".
  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/imem_cache_if.sv
// Fetch port plus backing-memory refill port of the instruction cache.
// The slave modport is the cache; the master modport is the core and backing memory.
interface imem_cache_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_oe;
  logic [31:0]       imem_rdata;
  logic              imem_ready;
  logic              inv;
  logic              bmem_req;
  logic [ADDR_W-1:0] bmem_addr;
  logic              bmem_ack;
  logic              bmem_rvalid;
  logic [31:0]       bmem_rdata;

  modport slave (
    input  imem_addr, imem_oe, inv, bmem_ack, bmem_rvalid, bmem_rdata,
    output imem_rdata, imem_ready, bmem_req, bmem_addr
  );

  modport master (
    output imem_addr, imem_oe, inv, bmem_ack, bmem_rvalid, bmem_rdata,
    input  imem_rdata, imem_ready, bmem_req, bmem_addr
  );
endinterface

// File: rtl/imem_cache_ram.sv
// Single-port RAM with a registered read, written so that it maps onto block RAM.
// A read in the cycle after a write to the same address returns the new data.
module imem_cache_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end
endmodule

// File: rtl/imem_cache.sv
// Direct-mapped read-only instruction cache. A hit answers one cycle after the fetch.
// A miss stalls the core, refills the whole line from backing memory, then returns the word.
module imem_cache
  import imem_cache_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input logic         clk,
  input logic         rst,
  imem_cache_if.slave bus
);
  localparam int WOFS_W = $clog2(LINE_WORDS);
  localparam int OFS_W  = WOFS_W + 2;
  localparam int IDX_W  = $clog2(LINES);
  localparam int TAG_W  = ADDR_W - OFS_W - IDX_W;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg;
  logic                pending_reg;
  logic [LINES-1:0]    valid_reg;
  logic [31:0]         rdata_reg;
  logic [WOFS_W-1:0]   cnt_reg;
  logic                inv_seen_reg;

  logic [IDX_W-1:0]    idx_req, idx_in;
  logic [TAG_W-1:0]    tag_req, tag_q;
  logic [WOFS_W-1:0]   wofs_req, wofs_in;
  logic [31:0]         data_q;
  logic                hit, last_beat, fill_beat, valid_set;
  logic                accept, ready, req;
  logic [IDX_W-1:0]    tag_ram_addr;
  logic [IDX_W+WOFS_W-1:0] data_ram_addr;

  assign idx_req  = addr_reg[OFS_W +: IDX_W];
  assign tag_req  = addr_reg[ADDR_W-1 -: TAG_W];
  assign wofs_req = addr_reg[2 +: WOFS_W];
  assign idx_in   = bus.imem_addr[OFS_W +: IDX_W];
  assign wofs_in  = bus.imem_addr[2 +: WOFS_W];

  // An invalidate in the lookup cycle forces a miss so stale code is never returned.
  assign hit       = pending_reg && valid_reg[idx_req] && (tag_q == tag_req) && !bus.inv;
  assign fill_beat = (state_reg == ST_FILL) && bus.bmem_rvalid;
  assign last_beat = fill_beat && (cnt_reg == WOFS_W'(LINE_WORDS - 1));
  assign valid_set = last_beat && !inv_seen_reg && !bus.inv;

  // The RAMs follow the fetch address except while a refill owns them.
  assign tag_ram_addr  = (state_reg == ST_FILL) ? idx_req : idx_in;
  assign data_ram_addr = (state_reg == ST_FILL) ? {idx_req, cnt_reg} : {idx_in, wofs_in};

  imem_cache_ram #(
    .DATA_W (TAG_W),
    .DEPTH  (LINES)
  ) u_tag_ram (
    .clk   (clk),
    .we    (last_beat),
    .addr  (tag_ram_addr),
    .wdata (tag_req),
    .rdata (tag_q)
  );

  imem_cache_ram #(
    .DATA_W (32),
    .DEPTH  (LINES * LINE_WORDS)
  ) u_data_ram (
    .clk   (clk),
    .we    (fill_beat),
    .addr  (data_ram_addr),
    .wdata (bus.bmem_rdata),
    .rdata (data_q)
  );

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    ready      = 1'b1;
    req        = 1'b0;
    unique case (state_reg)
      ST_RUN: begin
        if (pending_reg && !hit) begin
          ready      = 1'b0;
          state_next = ST_REQ;
        end else begin
          accept = bus.imem_oe;
        end
      end
      ST_REQ: begin
        ready = 1'b0;
        req   = 1'b1;
        if (bus.bmem_ack) begin
          state_next = ST_FILL;
        end
      end
      ST_FILL: begin
        ready = 1'b0;
        if (last_beat) begin
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        accept     = bus.imem_oe;
        state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  assign bus.imem_ready = ready;
  assign bus.bmem_req   = req;
  assign bus.bmem_addr  = {tag_req, idx_req, {OFS_W{1'b0}}};
  assign bus.imem_rdata = (state_reg == ST_RUN && hit) ? data_q : rdata_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_RUN;
      addr_reg     <= '0;
      pending_reg  <= 1'b0;
      rdata_reg    <= '0;
      cnt_reg      <= '0;
      inv_seen_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg    <= bus.imem_addr;
        pending_reg <= 1'b1;
      end else if (state_reg == ST_RESP || (state_reg == ST_RUN && hit)) begin
        pending_reg <= 1'b0;
      end
      // The response register keeps the last word returned, whether from a hit or a refill.
      if (state_reg == ST_RUN && hit) begin
        rdata_reg <= data_q;
      end else if (fill_beat && cnt_reg == wofs_req) begin
        rdata_reg <= bus.bmem_rdata;
      end
      if (state_reg == ST_REQ && bus.bmem_ack) begin
        cnt_reg <= '0;
      end else if (fill_beat) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (state_reg == ST_RUN) begin
        inv_seen_reg <= 1'b0;
      end else if (bus.inv) begin
        inv_seen_reg <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_reg[gi] <= 1'b0;
      end else if (bus.inv) begin
        valid_reg[gi] <= 1'b0;
      end else if (valid_set && idx_req == IDX_W'(gi)) begin
        valid_reg[gi] <= 1'b1;
      end
    end
  end

endmodule
